ttt_engine: RTL and testbench
=============================

Name: ttt_engine

Overview:
- Game-side end of the user/engine handshake for Tic-tac-toe.
- Owns the board and consumes the user's move number and move strobe.
- Validates the move, detects wins and draws, and picks and places the FPGA's X move. It then requests the next user move or announces the result.
- Drives the board/result/draw/result-strobe/need-input signals that the user I/O block displays.

Parameters:
- FPGA_FIRST, 0: 1 = FPGA places the first move after reset; 0 = user moves first.
- RESTART_CYCLES, 16: idle cycles between the end of a game and the automatic new game. Used only with TTT_AUTORESTART_EN.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_move  input  4  user's square number. Values 1..9 are legal squares; anything else is rejected.
- i_validmove_stb  input  1  one-cycle strobe; i_move is valid in the same cycle.
- o_board  output  18  square 1 = [17:16] ... square 9 = [1:0]. Encoding: 00 empty, 01 O (user), 10 X (FPGA); 11 is never driven.
- o_result  output  2  0 none, 1 FPGA (X) win, 2 user (O) win.
- o_isdraw  output  1  high when the board is full with no win.
- o_result_stb  output  1  one-cycle pulse on game end.
- o_needinput  output  1  high while the engine waits for a user move.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_board=0, o_result=0, o_isdraw=0, o_result_stb=0, o_needinput=0.
  - State=INIT, scan index=1.
  - Reset asserted mid-game, including mid-scan, clears everything immediately. Any strobe during reset is ignored.
- INIT: one cycle. Go to FPGA_WIN if FPGA_FIRST, else to WAIT_USER.
- WAIT_USER:
  - o_needinput=1.
  - On i_validmove_stb: register o_needinput<=0 on that same edge, so the user block never re-reads. Latch i_move.
  - Move in 1..9 and square empty: write 01 and go to CHECK_USER.
  - Otherwise go to REJECT. This covers 0, 10..15 (e.g. newline char gives 10) and occupied squares.
- REJECT: one cycle, board unchanged. Return to WAIT_USER; o_needinput is high again 2 edges after the strobe.
- CHECK_USER:
  - The 8 lines (rows, columns, 2 diagonals) are evaluated combinationally.
  - O line complete: o_result=2, o_result_stb=1, go to DONE.
  - Else all 9 squares non-empty: o_isdraw=1, o_result_stb=1, go to DONE.
  - Else go to FPGA_WIN with index=1.
- FPGA_WIN:
  - One square per cycle, index 1..9.
  - If the square is empty and X there completes a line: place 10, go to CHECK_FPGA.
  - After index 9: go to FPGA_BLOCK with index=1.
- FPGA_BLOCK: same scan, testing whether O there would complete a line. First hit gets X. After index 9, go to FPGA_PICK.
- FPGA_PICK: one cycle. X goes to the first empty square in the fixed order 5,1,3,7,9,2,4,6,8.
- FPGA move latency: at most 9+9+1 cycles after CHECK_USER. Win always takes priority over block, and block over pick.
- CHECK_FPGA:
  - X line complete: o_result=1, stb, go to DONE.
  - Else full: o_isdraw=1, stb, go to DONE.
  - Else go to WAIT_USER.
- o_result_stb is exactly one cycle, issued together with the final board. o_result, o_isdraw and o_board are then held.
- DONE: o_needinput=0. Strobes are ignored.
- i_validmove_stb arriving outside WAIT_USER is ignored with no side effects.
- o_result and o_isdraw are never both non-zero.

Optional Feature:
- TTT_AUTORESTART_EN defined:
  - DONE counts RESTART_CYCLES cycles.
  - It then clears o_board, o_result and o_isdraw and goes to INIT, starting a new game that honours FPGA_FIRST.
  - The counter is reset asynchronously with everything else.
- Undefined: DONE is terminal until i_rst_n is asserted. No counter is built.

Test Plan:
- Reset, FPGA_FIRST=0; strobe move 5 -> o_board[9:8]=01. Within 21 cycles o_board[17:16]=10 (pick order) and o_needinput=1; o_result=0.
- In WAIT_USER, strobe moves 0, 10, then 5 while 5 is occupied -> board unchanged each time. o_needinput drops on the strobe edge and is back high 2 edges later; no o_result_stb.
- User 5,9,7 -> FPGA plays 1, 3, then 2 (win beats block at 8). o_board[17:12]=101010, o_result=1, single o_result_stb, o_needinput stays 0.
- User 1 -> FPGA 5; user 2 -> FPGA must play 3 (block); o_board[13:12]=10.
- User 5,9,2,4,7 -> FPGA 1,3,8,6. After the last user move: board full, o_isdraw=1, o_result=0, one stb pulse.
- Assert i_rst_n low during FPGA_WIN scan -> all outputs 0 with no clock edge. With TTT_AUTORESTART_EN and RESTART_CYCLES=4, after any win the board clears and o_needinput=1 within 4+2 cycles.

Source files
------------

// File: rtl/ttt_engine.sv
// rtl/ttt_engine.sv - Tic-tac-toe engine: owns the board, validates user O moves, plays X, reports win/draw.
// Define TTT_AUTORESTART_EN to start a new game RESTART_CYCLES cycles after each game ends.
module ttt_engine #(
    parameter int FPGA_FIRST     = 0,
    parameter int RESTART_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_move,
    input  logic        i_validmove_stb,
    output logic [17:0] o_board,
    output logic [1:0]  o_result,
    output logic        o_isdraw,
    output logic        o_result_stb,
    output logic        o_needinput
);

    typedef enum logic [3:0] {
        S_INIT,
        S_WAIT_USER,
        S_REJECT,
        S_CHECK_USER,
        S_FPGA_WIN,
        S_FPGA_BLOCK,
        S_FPGA_PICK,
        S_CHECK_FPGA,
        S_DONE
    } state_t;

    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] MARK_O = 2'b01;
    localparam logic [1:0] MARK_X = 2'b10;

    // Each hex digit is a square number: rows, columns, diagonals
    localparam logic [11:0] LINES [8] = '{
        12'h123, 12'h456, 12'h789,
        12'h147, 12'h258, 12'h369,
        12'h159, 12'h357
    };
    localparam logic [3:0] PICK_ORDER [9] = '{
        4'd5, 4'd1, 4'd3, 4'd7, 4'd9, 4'd2, 4'd4, 4'd6, 4'd8
    };

    state_t      r_state;
    state_t      w_next_state;
    logic [17:0] r_board;
    logic [17:0] w_board_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_nxt;
    logic [1:0]  r_result;
    logic [1:0]  w_result_nxt;
    logic        r_isdraw;
    logic        w_isdraw_nxt;
    logic        r_result_stb;
    logic        w_result_stb_nxt;
    logic        r_needinput;
    logic        w_needinput_nxt;

    logic        w_move_legal;
    logic [3:0]  w_move_sq;
    logic        w_user_ok;
    logic        w_idx_empty;
    logic        w_win_hit;
    logic        w_block_hit;
    logic        w_o_line;
    logic        w_x_line;
    logic        w_full;
    logic [3:0]  w_pick_sq;
    logic        w_pick_found;
    logic        w_restart;

    // Square k (1..9) sits at bits [19-2k:18-2k]
    function automatic logic [1:0] sq(input logic [17:0] b, input logic [3:0] k);
        return b[5'(18 - 2 * k) +: 2];
    endfunction

    function automatic logic [17:0] put(input logic [17:0] b, input logic [3:0] k,
                                        input logic [1:0] m);
        logic [17:0] nb;
        nb = b;
        nb[5'(18 - 2 * k) +: 2] = m;
        return nb;
    endfunction

    function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (sq(b, LINES[l][11:8]) == m && sq(b, LINES[l][7:4]) == m &&
                sq(b, LINES[l][3:0]) == m)
                hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_full(input logic [17:0] b);
        logic full;
        full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (b[5'(2 * i) +: 2] == EMPTY)
                full = 1'b0;
        end
        return full;
    endfunction

    // Out-of-range moves are redirected to square 1 so the board lookup stays in range
    assign w_move_legal = (i_move >= 4'd1) && (i_move <= 4'd9);
    assign w_move_sq    = w_move_legal ? i_move : 4'd1;
    assign w_user_ok    = w_move_legal && (sq(r_board, w_move_sq) == EMPTY);

    assign w_idx_empty  = (sq(r_board, r_idx) == EMPTY);
    assign w_win_hit    = w_idx_empty && has_line(put(r_board, r_idx, MARK_X), MARK_X);
    assign w_block_hit  = w_idx_empty && has_line(put(r_board, r_idx, MARK_O), MARK_O);
    assign w_o_line     = has_line(r_board, MARK_O);
    assign w_x_line     = has_line(r_board, MARK_X);
    assign w_full       = is_full(r_board);

    always_comb begin
        w_pick_sq    = 4'd5;
        w_pick_found = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (!w_pick_found && sq(r_board, PICK_ORDER[i]) == EMPTY) begin
                w_pick_sq    = PICK_ORDER[i];
                w_pick_found = 1'b1;
            end
        end
    end

`ifdef TTT_AUTORESTART_EN
    localparam int CNT_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign w_restart = (r_cnt == CNT_W'(RESTART_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (r_state == S_DONE && !w_restart)
            r_cnt <= r_cnt + 1'b1;
        else
            r_cnt <= '0;
    end
`else
    assign w_restart = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_INIT;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:       w_next_state = (FPGA_FIRST != 0) ? S_FPGA_WIN : S_WAIT_USER;
            S_WAIT_USER: begin
                if (i_validmove_stb)
                    w_next_state = w_user_ok ? S_CHECK_USER : S_REJECT;
            end
            S_REJECT:     w_next_state = S_WAIT_USER;
            S_CHECK_USER: w_next_state = (w_o_line || w_full) ? S_DONE : S_FPGA_WIN;
            S_FPGA_WIN: begin
                if (w_win_hit)
                    w_next_state = S_CHECK_FPGA;
                else if (r_idx == 4'd9)
                    w_next_state = S_FPGA_BLOCK;
            end
            S_FPGA_BLOCK: begin
                if (w_block_hit)
                    w_next_state = S_CHECK_FPGA;
                else if (r_idx == 4'd9)
                    w_next_state = S_FPGA_PICK;
            end
            S_FPGA_PICK:  w_next_state = S_CHECK_FPGA;
            S_CHECK_FPGA: w_next_state = (w_x_line || w_full) ? S_DONE : S_WAIT_USER;
            S_DONE: begin
                if (w_restart)
                    w_next_state = S_INIT;
            end
            default:      w_next_state = S_INIT;
        endcase
    end

    // Registered outputs: needinput follows the state being entered, so it drops on the strobe edge
    always_comb begin
        w_board_nxt      = r_board;
        w_idx_nxt        = r_idx;
        w_result_nxt     = r_result;
        w_isdraw_nxt     = r_isdraw;
        w_result_stb_nxt = 1'b0;
        w_needinput_nxt  = (w_next_state == S_WAIT_USER);
        case (r_state)
            S_INIT:       w_idx_nxt = 4'd1;
            S_WAIT_USER: begin
                if (i_validmove_stb && w_user_ok)
                    w_board_nxt = put(r_board, w_move_sq, MARK_O);
            end
            S_CHECK_USER: begin
                if (w_o_line) begin
                    w_result_nxt     = 2'd2;
                    w_result_stb_nxt = 1'b1;
                end else if (w_full) begin
                    w_isdraw_nxt     = 1'b1;
                    w_result_stb_nxt = 1'b1;
                end else begin
                    w_idx_nxt = 4'd1;
                end
            end
            S_FPGA_WIN, S_FPGA_BLOCK: begin
                if ((r_state == S_FPGA_WIN) ? w_win_hit : w_block_hit) begin
                    w_board_nxt = put(r_board, r_idx, MARK_X);
                    w_idx_nxt   = 4'd1;
                end else if (r_idx == 4'd9) begin
                    w_idx_nxt = 4'd1;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            S_FPGA_PICK:  w_board_nxt = put(r_board, w_pick_sq, MARK_X);
            S_CHECK_FPGA: begin
                if (w_x_line) begin
                    w_result_nxt     = 2'd1;
                    w_result_stb_nxt = 1'b1;
                end else if (w_full) begin
                    w_isdraw_nxt     = 1'b1;
                    w_result_stb_nxt = 1'b1;
                end
            end
            S_DONE: begin
                if (w_restart) begin
                    w_board_nxt  = '0;
                    w_result_nxt = 2'd0;
                    w_isdraw_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_board      <= '0;
            r_idx        <= 4'd1;
            r_result     <= 2'd0;
            r_isdraw     <= 1'b0;
            r_result_stb <= 1'b0;
            r_needinput  <= 1'b0;
        end else begin
            r_board      <= w_board_nxt;
            r_idx        <= w_idx_nxt;
            r_result     <= w_result_nxt;
            r_isdraw     <= w_isdraw_nxt;
            r_result_stb <= w_result_stb_nxt;
            r_needinput  <= w_needinput_nxt;
        end
    end

    assign o_board      = r_board;
    assign o_result     = r_result;
    assign o_isdraw     = r_isdraw;
    assign o_result_stb = r_result_stb;
    assign o_needinput  = r_needinput;

endmodule

// File: tb/tb_ttt_engine.sv
// tb/tb_ttt_engine.sv - Scoreboard bench for ttt_engine against a rule-level game model.
module tb_ttt_engine;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [3:0]  i_move = 4'd0;
    logic        i_validmove_stb = 1'b0;
    logic [17:0] o_board;
    logic [1:0]  o_result;
    logic        o_isdraw;
    logic        o_result_stb;
    logic        o_needinput;

    always #5 i_clk = ~i_clk;

    ttt_engine dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_move          (i_move),
        .i_validmove_stb (i_validmove_stb),
        .o_board         (o_board),
        .o_result        (o_result),
        .o_isdraw        (o_isdraw),
        .o_result_stb    (o_result_stb),
        .o_needinput     (o_needinput)
    );

    typedef struct packed {
        logic        is_end;
        logic [17:0] board;
        logic [1:0]  result;
        logic        draw;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model board: 0 empty, 1 O (user), 2 X (FPGA)
    int m_board [1:9];
    bit m_over;
    int m_res;
    bit m_draw;
    int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                         '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
    int pick_order [9] = '{5, 1, 3, 7, 9, 2, 4, 6, 8};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit wins(input int b [1:9], input int p);
        for (int l = 0; l < 8; l++)
            if (b[lines[l][0]] == p && b[lines[l][1]] == p && b[lines[l][2]] == p)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit full(input int b [1:9]);
        for (int k = 1; k <= 9; k++)
            if (b[k] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [17:0] m_pack();
        logic [17:0] v;
        v = '0;
        for (int k = 1; k <= 9; k++) v[18 - 2 * k +: 2] = 2'(m_board[k]);
        return v;
    endfunction

    function automatic int fpga_choice();
        int b [1:9];
        for (int p = 2; p >= 1; p--) begin
            for (int k = 1; k <= 9; k++) begin
                if (m_board[k] == 0) begin
                    b = m_board;
                    b[k] = p;
                    if (wins(b, p)) return k;
                end
            end
        end
        for (int i = 0; i < 9; i++)
            if (m_board[pick_order[i]] == 0) return pick_order[i];
        return 0;
    endfunction

    function automatic void push(input bit is_end, input int res, input bit draw);
        exp_t e;
        e.is_end = is_end;
        e.board  = m_pack();
        e.result = 2'(res);
        e.draw   = draw;
        exp_q.push_back(e);
        if (is_end) begin
            m_over = 1'b1;
            m_res  = res;
            m_draw = draw;
        end
    endfunction

    // Returns 1 when the move is rejected
    function automatic bit m_apply(input int mv);
        int k;
        if (mv < 1 || mv > 9 || m_board[mv] != 0) begin
            push(1'b0, 0, 1'b0);
            return 1'b1;
        end
        m_board[mv] = 1;
        if (wins(m_board, 1))      push(1'b1, 2, 1'b0);
        else if (full(m_board))    push(1'b1, 0, 1'b1);
        else begin
            k = fpga_choice();
            m_board[k] = 2;
            if (wins(m_board, 2))   push(1'b1, 1, 1'b0);
            else if (full(m_board)) push(1'b1, 0, 1'b1);
            else                    push(1'b0, 0, 1'b0);
        end
        return 1'b0;
    endfunction

    function automatic int gen_move();
        int empt[$];
        int occ[$];
        for (int k = 1; k <= 9; k++)
            if (m_board[k] == 0) empt.push_back(k); else occ.push_back(k);
        if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 2))
                0:       return 0;
                1:       return int'($urandom_range(10, 15));
                default: return (occ.size() > 0) ? occ[$urandom_range(0, occ.size() - 1)] : 0;
            endcase
        end
        return empt[$urandom_range(0, empt.size() - 1)];
    endfunction

    logic prev_need = 1'b0;
    logic prev_stb  = 1'b0;

    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst_n) begin
            prev_need = 1'b0;
            prev_stb  = 1'b0;
        end else begin
            if (o_result_stb) check("stb_single_cycle", prev_stb, 1'b0);
            if ((o_needinput && !prev_need) || o_result_stb) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: need=%0b stb=%0b board=%h, expected none",
                             o_needinput, o_result_stb, o_board);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_end", o_result_stb, e.is_end);
                    check("event_board", o_board, e.board);
                    check("event_result", o_result, e.result);
                    check("event_draw", o_isdraw, e.draw);
                    if (e.is_end)
                        check("result_draw_excl", (o_result != 2'd0) && o_isdraw, 1'b0);
                end
            end
            prev_need = o_needinput;
            prev_stb  = o_result_stb;
        end
    end

    task automatic model_clear();
        exp_q.delete();
        for (int k = 1; k <= 9; k++) m_board[k] = 0;
        m_over = 1'b0;
        m_res  = 0;
        m_draw = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_move = 4'd5;
        i_validmove_stb = 1'b1;
        @(negedge i_clk);
        i_validmove_stb = 1'b0;
        check("rst_board", o_board, 18'd0);
        check("rst_result", o_result, 2'd0);
        check("rst_draw", o_isdraw, 1'b0);
        check("rst_stb", o_result_stb, 1'b0);
        check("rst_need", o_needinput, 1'b0);
        model_clear();
        push(1'b0, 0, 1'b0);
        i_rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 24) begin
            @(negedge i_clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic play_move(input int mv, input bit stray);
        bit rej;
        i_move = 4'(mv);
        i_validmove_stb = 1'b1;
        rej = m_apply(mv);
        @(negedge i_clk);
        i_validmove_stb = 1'b0;
        check("need_drop", o_needinput, 1'b0);
        if (rej) begin
            @(negedge i_clk);
            check("need_back", o_needinput, 1'b1);
        end else if (stray) begin
            i_move = 4'($urandom_range(1, 9));
            i_validmove_stb = 1'b1;
            @(negedge i_clk);
            i_validmove_stb = 1'b0;
        end
        wait_idle("move_latency");
        if (!m_over) check("need_high", o_needinput, 1'b1);
    endtask

    task automatic end_hold();
        int mv;
        mv = 1;
        for (int k = 9; k >= 1; k--) if (m_board[k] == 0) mv = k;
        repeat (2) @(negedge i_clk);
        i_move = 4'(mv);
        i_validmove_stb = 1'b1;
        @(negedge i_clk);
        i_validmove_stb = 1'b0;
        repeat (2) @(negedge i_clk);
        check("done_board", o_board, m_pack());
        check("done_result", o_result, 2'(m_res));
        check("done_draw", o_isdraw, m_draw);
        check("done_need", o_needinput, 1'b0);
    endtask

    initial begin
        do_reset();
        wait_idle("init_need");
        play_move(5, 1'b0);
        check("pick_sq1", o_board[17:16], 2'b10);
        check("pick_no_result", o_result, 2'd0);
        play_move(0, 1'b0);
        play_move(10, 1'b0);
        play_move(5, 1'b0);
        check("reject_board", o_board, 18'h20100);
        play_move(9, 1'b1);
        play_move(7, 1'b0);
        check("win_row", o_board[17:12], 6'b101010);
        check("win_result", o_result, 2'd1);
        end_hold();

        do_reset();
        wait_idle("init_need");
        play_move(1, 1'b0);
        play_move(2, 1'b0);
        check("block_sq3", o_board[13:12], 2'b10);

        do_reset();
        wait_idle("init_need");
        play_move(5, 1'b0);
        play_move(9, 1'b0);
        play_move(2, 1'b0);
        play_move(4, 1'b0);
        play_move(7, 1'b0);
        check("draw_flag", o_isdraw, 1'b1);
        check("draw_result", o_result, 2'd0);
        end_hold();

        do_reset();
        wait_idle("init_need");
        i_move = 4'd5;
        i_validmove_stb = 1'b1;
        @(negedge i_clk);
        i_validmove_stb = 1'b0;
        repeat (3) @(negedge i_clk);
        check("scan_busy", o_needinput, 1'b0);
        check("scan_board", o_board, 18'h00100);
        #2 i_rst_n = 1'b0;
        #1;
        check("async_rst_board", o_board, 18'd0);
        check("async_rst_need", o_needinput, 1'b0);
        check("async_rst_result", o_result, 2'd0);
        model_clear();

        repeat (30) begin
            do_reset();
            wait_idle("init_need");
            while (!m_over) play_move(gen_move(), 1'($urandom_range(0, 1)));
            end_hold();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
